// File: rtl/aes_pkg.sv
// AES-128 key schedule shared types, constants and GF(2^8) helpers.
// Used by aes_key_expander, its interface and aes_key_step.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  localparam int NR = 10;
  localparam int KW = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; 0 maps to 0 naturally
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq = gf_mul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key load and round-key read bundle for aes_key_expander.
// AES_KEY_EXP_REVERSE_EN adds rd_rev for decrypt-order reads.
interface aes_key_expander_if;
  import aes_pkg::*;

  logic [KW-1:0] key_in;
  logic          key_valid;
  logic          key_ready;
  logic          busy;
  logic          keys_valid;
  logic [3:0]    rd_idx;
  logic [KW-1:0] rd_key;
`ifdef AES_KEY_EXP_REVERSE_EN
  logic          rd_rev;

  modport master (
    output key_in, key_valid, rd_idx, rd_rev,
    input  key_ready, busy, keys_valid, rd_key
  );

  modport slave (
    input  key_in, key_valid, rd_idx, rd_rev,
    output key_ready, busy, keys_valid, rd_key
  );
`else
  modport master (
    output key_in, key_valid, rd_idx,
    input  key_ready, busy, keys_valid, rd_key
  );

  modport slave (
    input  key_in, key_valid, rd_idx,
    output key_ready, busy, keys_valid, rd_key
  );
`endif

endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key schedule round, purely combinational.
// aes_sbox is the forward S-box: GF inverse then affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  logic [7:0] inv;

  assign inv = gf_inv(a);

  assign s = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;

endmodule

module aes_key_step
  import aes_pkg::*;
(
  input  logic [KW-1:0] prev,
  input  logic [31:0]   rcon_word,
  output logic [KW-1:0] next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  // word 0 is the leftmost (first) 32 bits of the key
  assign w0 = prev[127:96];
  assign w1 = prev[95:64];
  assign w2 = prev[63:32];
  assign w3 = prev[31:0];

  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot[8*g +: 8]),
      .s (sub[8*g +: 8])
    );
  end

  assign t  = sub ^ rcon_word;
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key expander: one round per clock, 11-key table.
// AES_KEY_EXP_REVERSE_EN enables reversed (decrypt-order) reads.
module aes_key_expander
  import aes_pkg::*;
(
  input logic               clk,
  input logic               rst,
  aes_key_expander_if.slave bus
);

  localparam logic [3:0] LAST = 4'(NR);

  state_t        state;
  logic [3:0]    cnt;
  logic [7:0]    rcon;
  logic [KW-1:0] prev;
  logic [KW-1:0] next;
  logic [KW-1:0] rk [0:NR];
  logic          keys_valid;
  logic          accept;
  logic [3:0]    sel;

  assign bus.key_ready  = (state != EXPAND);
  assign bus.busy       = (state == EXPAND);
  assign bus.keys_valid = keys_valid;

  assign accept = bus.key_valid && (state != EXPAND);

  aes_key_step u_step (
    .prev      (prev),
    .rcon_word ({rcon, 24'h0}),
    .next      (next)
  );

  // FSM, round counter, rcon and chaining register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      rcon       <= RCON_INIT;
      keys_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            state      <= EXPAND;
            prev       <= bus.key_in;
            cnt        <= 4'd1;
            rcon       <= RCON_INIT;
            keys_valid <= 1'b0;
          end
        end
        EXPAND: begin
          prev <= next;
          rcon <= xtime(rcon);
          if (cnt == LAST) begin
            state      <= DONE;
            cnt        <= 4'd0;
            keys_valid <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // round-key table; never cleared, hidden by keys_valid instead
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        rk[0] <= bus.key_in;
      end else if (state == EXPAND) begin
        rk[cnt] <= next;
      end
    end
  end

`ifdef AES_KEY_EXP_REVERSE_EN
  assign sel = bus.rd_rev ? (LAST - bus.rd_idx) : bus.rd_idx;
`else
  assign sel = bus.rd_idx;
`endif

  // combinational read, zero unless the whole table is valid
  always_comb begin
    bus.rd_key = '0;
    if (keys_valid && (bus.rd_idx <= LAST)) begin
      bus.rd_key = rk[sel];
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander using FIPS-197 vectors.
// Define AES_KEY_EXP_REVERSE_EN to also cover reversed reads.
module tb_aes_key_expander;
  import aes_pkg::*;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb [$];

  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO = 128'h0;

  logic [127:0] fips_rk [0:10];
  logic [7:0]   rc_tab [0:9];

  aes_key_expander_if bus ();

  aes_key_expander dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_fips(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sb.push_back('{idx: 4'(i), key: fips_rk[i]});
    end
  endtask

  task automatic push_zero();
    sb.push_back('{idx: 4'd0,  key: ZERO});
    sb.push_back('{idx: 4'd1,  key: 128'h62636363626363636263636362636363});
    sb.push_back('{idx: 4'd2,  key: 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa});
    sb.push_back('{idx: 4'd10, key: 128'hb4ef5bcb3e92e21123e951cf6f8f188e});
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.rd_idx = e.idx;
      #1;
      n_checks++;
      if (bus.rd_key !== e.key) begin
        n_fail++;
        $display("FAIL %s rk[%0d]: got %h want %h", tag, e.idx, bus.rd_key, e.key);
      end
    end
  endtask

  task automatic accept(input logic [127:0] k);
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.keys_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0 || bus.keys_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset flags: ready=%b busy=%b kv=%b want 1 0 0",
               bus.key_ready, bus.busy, bus.keys_valid);
    end
    n_checks++;
    if (dut.rcon !== 8'h01) begin
      n_fail++;
      $display("FAIL reset rcon: got %h want 01", dut.rcon);
    end
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      n_checks++;
      if (bus.rd_key !== ZERO) begin
        n_fail++;
        $display("FAIL reset read idx %0d: got %h want 0", i, bus.rd_key);
      end
    end
  endtask

  task automatic test_fips();
    int n;
    accept(FIPS);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.key_ready !== 1'b0 || bus.rd_key !== ZERO) begin
      n_fail++;
      $display("FAIL fips expand flags: busy=%b ready=%b rd=%h want 1 0 0",
               bus.busy, bus.key_ready, bus.rd_key);
    end
    wait_valid(n);
    n_checks++;
    if (n !== 10) begin
      n_fail++;
      $display("FAIL fips latency: got %0d cycles want 10", n);
    end
    push_fips(0, 10);
    drain("fips");
    for (int i = 11; i < 16; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      n_checks++;
      if (bus.rd_key !== ZERO) begin
        n_fail++;
        $display("FAIL bounds idx %0d: got %h want 0", i, bus.rd_key);
      end
    end
  endtask

  task automatic test_rcon();
    accept(FIPS);
    for (int r = 0; r < 10; r++) begin
      n_checks++;
      if (dut.rcon !== rc_tab[r]) begin
        n_fail++;
        $display("FAIL rcon round %0d: got %h want %h", r + 1, dut.rcon, rc_tab[r]);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (bus.keys_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rcon done: keys_valid got %b want 1", bus.keys_valid);
    end
    sb.push_back('{idx: 4'd9, key: 128'hac7766f319fadc2128d12941575c006e});
    drain("rcon");
  endtask

  task automatic test_back_to_back();
    int lows;
    bus.key_in    = ZERO;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.key_in = FIPS;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.key_ready !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: ready=%b busy=%b want 0 1",
                 i, bus.key_ready, bus.busy);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (bus.keys_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b first done: keys_valid got %b want 1", bus.keys_valid);
    end
    push_zero();
    drain("b2b zero");
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    lows = 0;
    while (!bus.keys_valid && lows < 20) begin
      lows++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (lows !== 10) begin
      n_fail++;
      $display("FAIL b2b keys_valid low: got %0d cycles want 10", lows);
    end
    push_fips(0, 1);
    push_fips(10, 10);
    drain("b2b fips");
  endtask

`ifdef AES_KEY_EXP_REVERSE_EN
  task automatic test_reverse();
    bus.rd_rev = 1'b1;
    sb.push_back('{idx: 4'd0,  key: fips_rk[10]});
    sb.push_back('{idx: 4'd1,  key: fips_rk[9]});
    sb.push_back('{idx: 4'd10, key: fips_rk[0]});
    sb.push_back('{idx: 4'd12, key: ZERO});
    drain("reverse");
    bus.rd_rev = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    accept(FIPS);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0 || bus.keys_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid reset flags: ready=%b busy=%b kv=%b want 1 0 0",
               bus.key_ready, bus.busy, bus.keys_valid);
    end
    for (int i = 0; i < 16; i++) begin
      sb.push_back('{idx: 4'(i), key: ZERO});
    end
    drain("mid reset");
    rst           = 1'b1;
    bus.key_in    = ZERO;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.key_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst wins: busy got %b want 0", bus.busy);
    end
    accept(ZERO);
    wait_valid(n);
    n_checks++;
    if (n !== 10) begin
      n_fail++;
      $display("FAIL post reset latency: got %0d cycles want 10", n);
    end
    push_zero();
    drain("post reset");
  endtask

  initial begin
    fips_rk[0]  = FIPS;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.key_in    = ZERO;
    bus.key_valid = 1'b0;
    bus.rd_idx    = 4'd0;
`ifdef AES_KEY_EXP_REVERSE_EN
    bus.rd_rev    = 1'b0;
`endif
    test_reset();
    test_fips();
    test_rcon();
    test_back_to_back();
`ifdef AES_KEY_EXP_REVERSE_EN
    test_reverse();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
